// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, raises a request-to-send,
// shifts one command byte out on device clock falls and checks the device ack.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6500,
    parameter int TIMEOUT_CYCLES = 975000
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);
    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        DONE_WAIT,
        ERR
    } state_t;

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    // The REQ cycle keeps the clock held low, so INHIBIT stops one cycle early;
    // likewise ERR adds a cycle, so the timeout trips one cycle early.
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 2);
    localparam logic [TMO_W-1:0] TMO_TRIP = TMO_W'(TIMEOUT_CYCLES - 2);

    logic clk_s1;
    logic clk_s2;
    logic clk_prev;
    logic data_s1;
    logic data_s2;
    logic clk_fall;

    state_t           state;
    logic [8:0]       frame;
    logic [3:0]       bit_idx;
    logic [INH_W-1:0] inh_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;

    // Pads are asynchronous; idle bus level is high, so sync flops reset to 1.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data_in;
            data_s2  <= data_s1;
        end
    end

    assign clk_fall = clk_prev & ~clk_s2;
    assign tmo_hit  = (tmo_cnt == TMO_TRIP);

    always_ff @(posedge pclk) begin
        if (!rst) begin
            state       <= IDLE;
            frame       <= '0;
            bit_idx     <= '0;
            inh_cnt     <= '0;
            tmo_cnt     <= '0;
            tx_ready    <= 1'b0;
            busy        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (tx_valid && tx_ready) begin
                        frame      <= {~^tx_data, tx_data};
                        inh_cnt    <= '0;
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        state      <= INHIBIT;
                    end else begin
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                INHIBIT: begin
                    inh_cnt <= inh_cnt + 1'b1;
                    if (inh_cnt == INH_LAST) begin
                        ps2_data_oe <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    ps2_clk_oe <= 1'b0;
                    tmo_cnt    <= '0;
                    bit_idx    <= '0;
                    state      <= SHIFT;
                end
                SHIFT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (tmo_hit) begin
                        state <= ERR;
                    end else if (clk_fall) begin
                        if (bit_idx == 4'd9) begin
                            ps2_data_oe <= 1'b0;
                            state       <= ACK;
                        end else begin
                            ps2_data_oe <= ~frame[bit_idx];
                        end
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                ACK: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (tmo_hit) begin
                        state <= ERR;
                    end else if (clk_fall) begin
                        state <= data_s2 ? ERR : DONE_WAIT;
                    end
                end
                DONE_WAIT: begin
                    if (clk_s2 && data_s2) begin
                        tx_done  <= 1'b1;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                ERR: begin
                    tx_error    <= 1'b1;
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    tx_ready    <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: directed command bytes against a small PS/2 device model,
// with hand-computed line-drive patterns, pulse counts and timing.
module tb_ps2_host_tx;
    localparam int INH  = 20;
    localparam int TMO  = 2000;
    localparam int HALF = 20;

    logic       pclk     = 1'b0;
    logic       rst      = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_error;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    logic       clk_pad;
    logic       data_pad;

    int checks = 0;
    int errors = 0;
    int done_total = 0;
    int err_total = 0;
    int both_total = 0;
    int clk_oe_total = 0;
    int n;
    int done_base;
    int err_base;
    int oe_base;
    logic [10:0] seen;

    assign clk_pad  = dev_clk & ~ps2_clk_oe;
    assign data_pad = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (clk_pad),
        .ps2_data_in(data_pad),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (tx_done) done_total = done_total + 1;
        if (tx_error) err_total = err_total + 1;
        if (tx_done && tx_error) both_total = both_total + 1;
        if (ps2_clk_oe) clk_oe_total = clk_oe_total + 1;
    end

    task automatic tick(input int cycles);
        repeat (cycles) @(negedge pclk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] value, input logic hold);
        tx_data  = value;
        tx_valid = 1'b1;
        tick(1);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic waitRelease(input string tag);
        int cnt;
        cnt = 0;
        while (ps2_clk_oe && cnt < 200) begin
            tick(1);
            cnt = cnt + 1;
        end
        checkOutput(tag, {31'd0, ps2_clk_oe}, 32'd0);
    endtask

    // Device model: 40-cycle clock; optionally pulls data low across fall 11 as ack.
    task automatic deviceFrame(input int falls, input logic ack, output logic [10:0] oe_seen);
        oe_seen = '0;
        for (int k = 1; k <= falls; k++) begin
            if (k == 11 && ack) dev_data = 1'b0;
            tick(HALF);
            dev_clk = 1'b0;
            tick(HALF / 2);
            oe_seen[k-1] = ps2_data_oe;
            tick(HALF / 2);
            dev_clk = 1'b1;
        end
        if (falls == 11) begin
            tick(HALF);
            dev_data = 1'b1;
            tick(HALF);
        end
    endtask

    initial begin
        tick(3);
        checkOutput("rst_ready", {31'd0, tx_ready}, 32'd0);
        checkOutput("rst_outs", {26'd0, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_error, 1'b0}, 32'd0);
        rst = 1'b1;
        tick(1);
        checkOutput("rst_ready_after", {31'd0, tx_ready}, 32'd1);

        // 0xED acked: frame bits 1,0,1,1,0,1,1,1 + parity 1
        oe_base = clk_oe_total; done_base = done_total; err_base = err_total;
        applyStimulus(8'hED, 1'b0);
        checkOutput("t1_busy", {31'd0, busy}, 32'd1);
        checkOutput("t1_ready_low", {31'd0, tx_ready}, 32'd0);
        waitRelease("t1_release");
        checkOutput("t1_start_bit", {31'd0, ps2_data_oe}, 32'd1);
        checkOutput("t1_clk_oe_cycles", clk_oe_total - oe_base, INH);
        deviceFrame(11, 1'b1, seen);
        for (int k = 0; k < 9; k++) begin
            logic [8:0] exp_oe;
            exp_oe = 9'b0_0001_0010;
            checkOutput($sformatf("t1_fall%0d", k + 1), {31'd0, seen[k]}, {31'd0, exp_oe[k]});
        end
        checkOutput("t1_stop_released", {31'd0, seen[9]}, 32'd0);
        tick(10);
        checkOutput("t1_done_count", done_total - done_base, 32'd1);
        checkOutput("t1_err_count", err_total - err_base, 32'd0);
        checkOutput("t1_ready_back", {31'd0, tx_ready}, 32'd1);
        checkOutput("t1_idle_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);

        // 0x00 acked: parity 1, so data released at fall 9
        done_base = done_total; err_base = err_total;
        applyStimulus(8'h00, 1'b0);
        waitRelease("t2_release");
        deviceFrame(11, 1'b1, seen);
        checkOutput("t2_frame", {22'd0, seen[9:0]}, {22'd0, 10'b00_1111_1111});
        tick(10);
        checkOutput("t2_done_count", done_total - done_base, 32'd1);
        checkOutput("t2_err_count", err_total - err_base, 32'd0);

        // 0x55 with no ack
        done_base = done_total; err_base = err_total;
        applyStimulus(8'h55, 1'b0);
        waitRelease("t3_release");
        deviceFrame(11, 1'b0, seen);
        checkOutput("t3_frame", {22'd0, seen[9:0]}, {22'd0, 10'b00_1010_1010});
        tick(10);
        checkOutput("t3_err_count", err_total - err_base, 32'd1);
        checkOutput("t3_done_count", done_total - done_base, 32'd0);
        checkOutput("t3_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        checkOutput("t3_ready", {31'd0, tx_ready}, 32'd1);

        // 0xFF with a silent device: timeout
        done_base = done_total; err_base = err_total;
        applyStimulus(8'hFF, 1'b0);
        waitRelease("t4_release");
        n = 0;
        while (!tx_error && n < 3000) begin
            tick(1);
            n = n + 1;
        end
        checkOutput("t4_timeout_cycles", n, TMO);
        checkOutput("t4_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        tick(1);
        checkOutput("t4_pulse_width", {31'd0, tx_error}, 32'd0);
        checkOutput("t4_done_count", done_total - done_base, 32'd0);

        // 0xF4 interrupted by reset at fall 5
        done_base = done_total; err_base = err_total;
        applyStimulus(8'hF4, 1'b0);
        waitRelease("t5_release");
        deviceFrame(4, 1'b0, seen);
        checkOutput("t5_first_bits", {28'd0, seen[3:0]}, 32'b1011);
        tick(HALF);
        dev_clk = 1'b0;
        rst = 1'b0;
        tick(1);
        checkOutput("t5_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        checkOutput("t5_busy_ready", {30'd0, busy, tx_ready}, 32'd0);
        dev_clk = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(1);
        checkOutput("t5_ready_after", {31'd0, tx_ready}, 32'd1);
        checkOutput("t5_no_pulses", (done_total - done_base) + (err_total - err_base), 32'd0);

        // valid held across 0x12 then 0x34: only 0x12 now, 0x34 next
        done_base = done_total; err_base = err_total;
        applyStimulus(8'h12, 1'b1);
        tx_data = 8'h34;
        checkOutput("t6_ready_low", {31'd0, tx_ready}, 32'd0);
        waitRelease("t6_release1");
        deviceFrame(11, 1'b1, seen);
        checkOutput("t6_frame1", {22'd0, seen[9:0]}, {22'd0, 10'b00_1110_1101});
        checkOutput("t6_done1", done_total - done_base, 32'd1);
        checkOutput("t6_second_busy", {31'd0, busy}, 32'd1);
        tx_valid = 1'b0;
        waitRelease("t6_release2");
        deviceFrame(11, 1'b1, seen);
        checkOutput("t6_frame2", {22'd0, seen[9:0]}, {22'd0, 10'b01_1100_1011});
        tick(10);
        checkOutput("t6_done2", done_total - done_base, 32'd2);
        checkOutput("t6_err", err_total - err_base, 32'd0);
        checkOutput("never_both_pulses", both_total, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
